// File: rtl/scope_capture_pkg.sv
// Shared types for the triggered scope capture buffer.
package scope_capture_pkg;
    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} cap_state_t;
endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port A writes, port B reads through a resettable output register.
module dpram #(
    parameter int AW = 13,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] doutb
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wea) mem[addra] <= dina;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   doutb <= '0;
        else if (enb) doutb <= mem[addrb];
    end
endmodule

// File: rtl/scope_capture_buf.sv
// Triggered ring-buffer waveform capture with record-relative readout.
// Optional sample decimation is enabled by defining SCOPE_DECIM_EN (adds port decim).
module scope_capture_buf
    import scope_capture_pkg::*;
#(
    parameter int BUF_AW = 13,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    input  logic              arm,
    input  logic              trig_ext,
    input  logic              trig_src,
    input  logic [DW-1:0]     trig_level,
    input  logic [BUF_AW-1:0] pre_len,
    input  logic [BUF_AW-1:0] post_len,
`ifdef SCOPE_DECIM_EN
    input  logic [7:0]        decim,
`endif
    input  logic              rd_strobe,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [BUF_AW-1:0] trig_ptr
);
    localparam int CW = BUF_AW + 1;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {BUF_AW{1'b0}}};

    cap_state_t        state;
    logic [BUF_AW-1:0] wptr;
    logic [CW-1:0]     cnt, cnt_inc, post_req, room, post_eff;
    logic              acc, we;
    logic              trig_ext_d, ext_pend, ext_edge, ext_hit;
    logic [DW-1:0]     prev;
    logic              prev_ok, lvl_hit, trig_evt;
    logic [BUF_AW-1:0] rd_phys;
    logic [1:0]        vld_pipe;

`ifdef SCOPE_DECIM_EN
    logic [7:0] dcnt;

    // Keep the first valid sample after arm, then every (decim+1)-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         dcnt <= '0;
        else if (arm)       dcnt <= '0;
        else if (din_valid) dcnt <= (dcnt == decim) ? 8'd0 : dcnt + 8'd1;
    end
    assign acc = din_valid && (dcnt == 8'd0);
`else
    assign acc = din_valid;
`endif

    // An edge arriving between accepted samples waits for the next one.
    assign ext_edge = trig_ext & ~trig_ext_d;
    assign ext_hit  = ext_edge | ext_pend;
    assign lvl_hit  = prev_ok && ($signed(prev) < $signed(trig_level))
                              && ($signed(trig_level) <= $signed(din));
    assign trig_evt = acc && (trig_src ? ext_hit : lvl_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_ext_d <= 1'b0;
            ext_pend   <= 1'b0;
            prev       <= '0;
            prev_ok    <= 1'b0;
        end else begin
            trig_ext_d <= trig_ext;
            if (arm || acc)    ext_pend <= 1'b0;
            else if (ext_edge) ext_pend <= 1'b1;
            if (arm) begin
                prev_ok <= 1'b0;
            end else if (acc) begin
                prev    <= din;
                prev_ok <= 1'b1;
            end
        end
    end

    // Post-trigger length is clipped so the record never exceeds the buffer.
    assign post_req = (post_len == '0) ? CW'(1) : {1'b0, post_len};
    assign room     = DEPTH_C - {1'b0, pre_len};
    assign post_eff = (post_req < room) ? post_req : room;
    assign cnt_inc  = cnt + CW'(1);
    assign we       = acc && !arm && (state == FILL || state == ARMED || state == POST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wptr     <= '0;
            trig_ptr <= '0;
        end else begin
            if (we) wptr <= wptr + 1'b1;
            if (arm) begin
                cnt   <= '0;
                state <= (pre_len == '0) ? ARMED : FILL;
            end else begin
                case (state)
                    FILL: if (acc) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == {1'b0, pre_len}) state <= ARMED;
                    end
                    ARMED: if (trig_evt) begin
                        trig_ptr <= wptr;
                        cnt      <= CW'(1);
                        state    <= (post_eff == CW'(1)) ? DONE : POST;
                    end
                    POST: if (acc) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == post_eff) state <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == FILL) || (state == ARMED) || (state == POST);
    assign done = (state == DONE);

    // Read pipe: address register, then registered RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_phys  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_strobe};
            if (rd_strobe) rd_phys <= trig_ptr - pre_len + rd_addr;
        end
    end
    assign rd_valid = vld_pipe[1];

    dpram #(.AW(BUF_AW), .DW(DW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (we),
        .addra (wptr),
        .dina  (din),
        .enb   (vld_pipe[0]),
        .addrb (rd_phys),
        .doutb (rd_data)
    );
endmodule

// File: tb/tb_scope_capture_buf.sv
// Directed bench for scope_capture_buf: capture, trigger modes, wrap, restart and reset.
module tb_scope_capture_buf;
    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;
`ifdef SCOPE_DECIM_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    logic clk = 0;
    logic rst_n = 0;
    logic [15:0] din = 0;
    logic din_valid = 0, arm = 0, trig_ext = 0, trig_src = 0;
    logic [15:0] trig_level = 0;
    logic [AW-1:0] pre_len = 0, post_len = 0, rd_addr = 0;
    logic rd_strobe = 0;
`ifdef SCOPE_DECIM_EN
    logic [7:0] decim = 0;
`endif
    logic [15:0] rd_data;
    logic rd_valid, busy, done;
    logic [AW-1:0] trig_ptr;

    int n_cmp = 0, n_bad = 0, wp = 0;
    logic signed [15:0] sv [0:299];

    always #5 clk = ~clk;

    scope_capture_buf #(.BUF_AW(AW), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .arm(arm),
        .trig_ext(trig_ext), .trig_src(trig_src), .trig_level(trig_level),
        .pre_len(pre_len), .post_len(post_len),
`ifdef SCOPE_DECIM_EN
        .decim(decim),
`endif
        .rd_strobe(rd_strobe), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .trig_ptr(trig_ptr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] d, input logic e);
        din = d; din_valid = 1; trig_ext = e;
        tick();
        din_valid = 0;
        wp++;
    endtask

    task automatic do_arm();
        arm = 1; tick(); arm = 0;
    endtask

    // Back-to-back strobes; expected data at rd_addr start+k is base + k*step.
    task automatic rd_burst(input string tag, input int start, input int n,
                            input int base, input int step);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                rd_addr = AW'(start + i); rd_strobe = 1;
            end else begin
                rd_strobe = 0;
            end
            tick();
            if (i >= 1) begin
                chk({tag, "_vld"}, 32'(rd_valid), 1);
                chk({tag, "_dat"}, 32'(rd_data), (base + (i - 1) * step) & 32'hFFFF);
            end
        end
    endtask

    initial begin
        #(500_000);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        logic [15:0] d;
        for (int n = 0; n < 300; n++)
            sv[n] = 16'($rtoi(2000.0 * $sin(2.0 * 3.14159265358979 * n / 64.0)));

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vld", 32'(rd_valid), 0);
        chk("rst_tp", 32'(trig_ptr), 0);
        chk("rst_rd", 32'(rd_data), 0);
        rst_n = 1;
        tick();

        // 1: ramp, external trigger at sample 500
        pre_len = 100; post_len = 200; trig_src = 1;
        do_arm();
        chk("t1_busy", 32'(busy), 1);
        i = 0;
        while (!done && i < 2000) begin push(16'(i), i == 500); i++; end
        chk("t1_len", i, 700);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy0", 32'(busy), 0);
        chk("t1_tp", 32'(trig_ptr), 500);
        rd_burst("t1", 0, 300, 400, 1);

        // 2: level trigger on sine, first eligible crossing is n=70
        pre_len = 20; post_len = 30; trig_src = 0; trig_level = 16'd1000;
        do_arm();
        chk("t2_done0", 32'(done), 0);
        i = 0;
        while (!done && i < 300) begin push(sv[i], 0); i++; end
        chk("t2_len", i, 100);
        chk("t2_tp", 32'(trig_ptr), 770);
        rd_burst("t2_hi", 20, 1, 32'(sv[70]), 0);
        rd_burst("t2_lo", 19, 1, 32'(sv[69]), 0);
        chk("t2_ge", 32'($signed(sv[70]) >= 1000), 1);
        chk("t2_lt", 32'($signed(sv[69]) < 1000), 1);

        // 2b: first sample after arm cannot fire; post_len 0 acts as 1
        pre_len = 0; post_len = 0;
        do_arm();
        push(16'd1500, 0);
        chk("t2b_first", 32'(done), 0);
        push(16'd500, 0);
        push(16'd1200, 0);
        chk("t2b_done", 32'(done), 1);
        chk("t2b_tp", 32'(trig_ptr), 802);

        // 3: edge during FILL ignored; later edge between samples held pending
        pre_len = 50; post_len = 10; trig_src = 1;
        do_arm();
        chk("t3_done0", 32'(done), 0);
        for (int k = 0; k < 100; k++) push(16'(1000 + k), k == 10);
        chk("t3_nodone", 32'(done), 0);
        chk("t3_busy", 32'(busy), 1);
        trig_ext = 1; tick(); trig_ext = 0; tick();
        i = 100;
        while (!done && i < 400) begin push(16'(1000 + i), 0); i++; end
        chk("t3_len", i, 110);
        chk("t3_tp", 32'(trig_ptr), 903);
        rd_burst("t3_a0", 0, 1, 1050, 0);
        rd_burst("t3_a50", 50, 1, 1100, 0);

        // 4: pre_len = DEPTH-1 clips post to 1; record wraps across address 0
        pre_len = AW'(DEPTH - 1); post_len = 100;
        do_arm();
        i = 0;
        while (!done && i < 9000) begin push(16'(i), i == 8200); i++; end
        chk("t4_len", i, 8201);
        chk("t4_tp", 32'(trig_ptr), 921);
        rd_burst("t4_wrap", 7267, 6, 9 + 7267, 1);
        rd_burst("t4_head", 0, 2, 9, 1);
        rd_burst("t4_tail", 8190, 2, 9 + 8190, 1);

        // 5: arm in POST restarts; reset mid-read clears everything
        pre_len = 10; post_len = 100;
        do_arm();
        for (int k = 0; k < 30; k++) push(16'(k), k == 15);
        chk("t5_post_busy", 32'(busy), 1);
        do_arm();
        chk("t5_rearm_busy", 32'(busy), 1);
        chk("t5_rearm_done", 32'(done), 0);
        for (int k = 0; k < 10; k++) push(16'(100 + k), 0);
        i = wp % DEPTH;
        push(16'd200, 1);
        chk("t5_tp", 32'(trig_ptr), i);
        push(16'd201, 0);
        rd_addr = 0; rd_strobe = 1; tick(); rd_strobe = 0;
        rst_n = 0; #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_tp", 32'(trig_ptr), 0);
        chk("t5_rst_rd", 32'(rd_data), 0);
        tick();
        chk("t5_rst_vld", 32'(rd_valid), 0);
        rst_n = 1;
        tick();

        // 5b: arm coinciding with a trigger edge -- arm wins
        pre_len = 0; post_len = 0; trig_ext = 0;
        din = 16'd7; din_valid = 1; trig_ext = 1; arm = 1;
        tick();
        arm = 0; din_valid = 0;
        chk("t5b_busy", 32'(busy), 1);
        push(16'd1, 1);
        push(16'd2, 1);
        chk("t5b_nofire", 32'(done), 0);
        push(16'd3, 0);
        push(16'd4, 1);
        chk("t5b_fire", 32'(done), 1);

        // 6: decimation step on a ramp (step 1 when the feature is absent)
        pre_len = 4; post_len = 4; trig_src = 1; trig_ext = 0;
`ifdef SCOPE_DECIM_EN
        decim = 8'd3;
`endif
        do_arm();
        i = 0;
        while (!done && i < 200) begin d = 16'(i); push(d, i == 40); i++; end
        chk("t6_done", 32'(done), 1);
        rd_burst("t6", 0, 8, 40 - 4 * STEP, STEP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
